tia_poly_counter: RTL and testbench

TIA_POLY_COUNTER -- requirements
Module: tia_poly_counter

---
 rtl/tia_pkg.sv | 13 +
 rtl/tia_d1x.sv | 43 ++++
 rtl/tia_poly_counter.sv | 97 +++++++++
 tb/tb_tia_poly_counter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_pkg.sv
// Shared constants for the TIA horizontal-count style polynomial counters.
package tia_pkg;

    localparam int TIA_HCOUNT_WIDTH = 6;
    localparam logic [TIA_HCOUNT_WIDTH-1:0] TIA_HCOUNT_WRAP = 6'b010100;
    localparam int TIA_TAP_A = 0;
    localparam int TIA_TAP_B = 1;

    // Two-phase sequencer: a phase-1 step stages NEXT(count), a phase-2 step commits it.
    localparam logic [0:0] PH_ONE = 1'b0;
    localparam logic [0:0] PH_TWO = 1'b1;

endpackage

// File: rtl/tia_d1x.sv
// One counter bit: a phase-1 staging latch feeding a phase-2 committed register.
module tia_d1x (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic ph1_en,
    input  logic ph2_en,
    input  logic next_bit,
    output logic tap_bit,
    output logic count_bit
);

    logic tap_q;
    logic tap_d;
    logic count_q;
    logic count_d;

    always_comb begin
        tap_d   = tap_q;
        count_d = count_q;
        if (clr) begin
            tap_d   = 1'b0;
            count_d = 1'b0;
        end else begin
            if (ph1_en) tap_d   = next_bit;
            if (ph2_en) count_d = tap_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_q   <= 1'b0;
            count_q <= 1'b0;
        end else begin
            tap_q   <= tap_d;
            count_q <= count_d;
        end
    end

    assign tap_bit   = tap_q;
    assign count_bit = count_q;

endmodule

// File: rtl/tia_poly_counter.sv
// Two-phase XNOR polynomial counter: WIDTH tia_d1x bit cells plus shared feedback,
// wrap decode and phase sequencing. All outputs are straight from flops.
module tia_poly_counter
    import tia_pkg::*;
#(
    parameter int               WIDTH = TIA_HCOUNT_WIDTH,
    parameter logic [WIDTH-1:0] WRAP  = WIDTH'(TIA_HCOUNT_WRAP),
    parameter int               TAP_A = TIA_TAP_A,
    parameter int               TAP_B = TIA_TAP_B
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic             phi1,
    output logic             phi2,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [0:0]       ph_q;
    logic [0:0]       ph_d;
    logic             phi1_q;
    logic             phi1_d;
    logic             phi2_q;
    logic             phi2_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             step1;
    logic             step2;
    logic             fb;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] tap_w;
    logic [WIDTH-1:0] count_w;

    // clr overrides en, so a cleared clk is never a step of either phase.
    assign step1 = en && !clr && (ph_q == PH_ONE);
    assign step2 = en && !clr && (ph_q == PH_TWO);

    // All-ones is the XNOR lockup state; it escapes to zero like the wrap state.
    always_comb begin
        fb       = ~(count_w[TAP_A] ^ count_w[TAP_B]);
        next_val = {fb, count_w[WIDTH-1:1]};
        if (count_w == WRAP) begin
            next_val = '0;
        end else if (&count_w) begin
            next_val = '0;
        end
    end

    always_comb begin
        ph_d   = ph_q;
        phi1_d = step1;
        phi2_d = step2;
        wrap_d = step2 && (count_w == WRAP) && (tap_w == '0);
        if (clr) begin
            ph_d = PH_ONE;
        end else if (en) begin
            ph_d = ~ph_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q   <= PH_ONE;
            phi1_q <= 1'b0;
            phi2_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            phi1_q <= phi1_d;
            phi2_q <= phi2_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tia_d1x u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr       (clr),
            .ph1_en    (step1),
            .ph2_en    (step2),
            .next_bit  (next_val[i]),
            .tap_bit   (tap_w[i]),
            .count_bit (count_w[i])
        );
    end

    assign phi1  = phi1_q;
    assign phi2  = phi2_q;
    assign wrap  = wrap_q;
    assign tap   = tap_w;
    assign count = count_w;

endmodule

// File: tb/tb_tia_poly_counter.sv
// Directed bench for tia_poly_counter: default 6-bit build plus a 4-bit build
// used for the lockup-escape case.
module tb_tia_poly_counter;

    localparam logic [5:0] WRAP6 = 6'b010100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic       phi1;
    logic       phi2;
    logic [5:0] tap;
    logic [5:0] count;
    logic       wrap;

    logic       reset_n4;
    logic       en4;
    logic       clr4;
    logic       phi1_4;
    logic       phi2_4;
    logic [3:0] tap4;
    logic [3:0] count4;
    logic       wrap4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tia_poly_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clr),
        .phi1    (phi1),
        .phi2    (phi2),
        .tap     (tap),
        .count   (count),
        .wrap    (wrap)
    );

    tia_poly_counter #(.WIDTH(4), .WRAP(4'b0101), .TAP_A(0), .TAP_B(1)) dut4 (
        .clk     (clk),
        .reset_n (reset_n4),
        .en      (en4),
        .clr     (clr4),
        .phi1    (phi1_4),
        .phi2    (phi2_4),
        .tap     (tap4),
        .count   (count4),
        .wrap    (wrap4)
    );

    function automatic logic [5:0] next_ref(input logic [5:0] c);
        if (c == WRAP6) return 6'b000000;
        if (c == 6'b111111) return 6'b000000;
        return {~(c[0] ^ c[1]), c[5:1]};
    endfunction

    task automatic step(input logic e, input logic c);
        en  = e;
        clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step4(input logic e);
        en4 = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        en      = 1'b0;
        clr     = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        en      = 1'b1;
        clr     = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 6'b0) begin failures++; $display("FAIL reset_count got=%b exp=%b", count, 6'b0); end
        checks++;
        if (tap !== 6'b0) begin failures++; $display("FAIL reset_tap got=%b exp=%b", tap, 6'b0); end
        checks++;
        if ({phi1, phi2, wrap} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000", {phi1, phi2, wrap});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (count !== 6'b0 || phi1 !== 1'b0) begin
            failures++; $display("FAIL reset_hold got count=%b phi1=%b exp count=000000 phi1=0", count, phi1);
        end
        reset_n = 1'b1;
        en      = 1'b0;
    endtask

    task automatic test_sequence();
        logic [5:0] exp_q[$];
        logic [5:0] exp_c;
        exp_q = '{6'b100000, 6'b110000, 6'b111000, 6'b111100};
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0);
            checks++;
            if (phi1 !== ((k % 2) == 1) || phi2 !== ((k % 2) == 0)) begin
                failures++; $display("FAIL seq_phi clk=%0d got phi1=%b phi2=%b", k, phi1, phi2);
            end
            if ((k % 2) == 1) begin
                checks++;
                if (tap !== exp_q[0]) begin
                    failures++; $display("FAIL seq_tap clk=%0d got=%b exp=%b", k, tap, exp_q[0]);
                end
            end else begin
                exp_c = exp_q.pop_front();
                checks++;
                if (count !== exp_c) begin
                    failures++; $display("FAIL seq_count clk=%0d got=%b exp=%b", k, count, exp_c);
                end
            end
        end
    endtask

    task automatic test_en_gaps();
        apply_reset();
        step(1'b1, 1'b0);
        checks++;
        if (phi1 !== 1'b1 || tap !== 6'b100000 || count !== 6'b0) begin
            failures++; $display("FAIL gap_ph1 got phi1=%b tap=%b count=%b", phi1, tap, count);
        end
        for (int k = 2; k <= 3; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (phi1 !== 1'b0 || phi2 !== 1'b0 || count !== 6'b0 || tap !== 6'b100000) begin
                failures++; $display("FAIL gap_hold clk=%0d got phi1=%b phi2=%b count=%b tap=%b", k, phi1, phi2, count, tap);
            end
        end
        step(1'b1, 1'b0);
        checks++;
        if (phi2 !== 1'b1 || phi1 !== 1'b0 || count !== 6'b100000) begin
            failures++; $display("FAIL gap_ph2 got phi2=%b phi1=%b count=%b exp 1 0 100000", phi2, phi1, count);
        end
    endtask

    task automatic test_clr();
        apply_reset();
        step(1'b1, 1'b0);
        checks++;
        if (tap !== 6'b100000) begin failures++; $display("FAIL clr_pre_tap got=%b exp=100000", tap); end
        step(1'b1, 1'b1);
        checks++;
        if (count !== 6'b0 || tap !== 6'b0 || wrap !== 1'b0 || phi1 !== 1'b0 || phi2 !== 1'b0) begin
            failures++; $display("FAIL clr_apply got count=%b tap=%b wrap=%b phi1=%b phi2=%b", count, tap, wrap, phi1, phi2);
        end
        step(1'b1, 1'b0);
        checks++;
        if (phi1 !== 1'b1 || phi2 !== 1'b0 || tap !== 6'b100000 || count !== 6'b0) begin
            failures++; $display("FAIL clr_after got phi1=%b phi2=%b tap=%b count=%b", phi1, phi2, tap, count);
        end
        step(1'b1, 1'b0);
        checks++;
        if (count !== 6'b100000 || wrap !== 1'b0) begin
            failures++; $display("FAIL clr_commit got count=%b wrap=%b exp 100000 0", count, wrap);
        end
    endtask

    task automatic test_wrap_period();
        logic [5:0] c;
        int steps;
        int period;
        int edges_q[$];
        int model_bad;
        c     = 6'b0;
        steps = 0;
        while (c != WRAP6 && steps < 100) begin
            c = next_ref(c);
            steps++;
        end
        period    = steps + 1;
        model_bad = 0;
        c         = 6'b0;
        apply_reset();
        for (int e = 1; e <= 4 * period + 4; e++) begin
            step(1'b1, 1'b0);
            if (wrap === 1'b1) edges_q.push_back(e);
            if ((e % 2) == 0) begin
                c = next_ref(c);
                if (count !== c && model_bad < 4) begin
                    model_bad++;
                    $display("FAIL wrap_run_count clk=%0d got=%b exp=%b", e, count, c);
                end
            end
        end
        checks++;
        if (model_bad != 0) failures++;
        checks++;
        if (edges_q.size() != 2) begin
            failures++; $display("FAIL wrap_pulses got=%0d exp=2", edges_q.size());
        end else begin
            checks++;
            if (edges_q[0] != 2 * period) begin
                failures++; $display("FAIL wrap_first got=%0d exp=%0d", edges_q[0], 2 * period);
            end
            checks++;
            if (edges_q[1] - edges_q[0] != 2 * period) begin
                failures++; $display("FAIL wrap_spacing got=%0d exp=%0d", edges_q[1] - edges_q[0], 2 * period);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 6'b0 || tap !== 6'b0 || {phi1, phi2, wrap} !== 3'b000) begin
            failures++; $display("FAIL async_rst got count=%b tap=%b strobes=%b", count, tap, {phi1, phi2, wrap});
        end
        #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0);
            checks++;
            if (wrap !== 1'b0 || phi1 !== ((k % 2) == 1)) begin
                failures++; $display("FAIL async_after clk=%0d got wrap=%b phi1=%b", k, wrap, phi1);
            end
            if (k == 2) begin
                checks++;
                if (count !== 6'b100000) begin
                    failures++; $display("FAIL async_count got=%b exp=100000", count);
                end
            end
        end
    endtask

    task automatic test_lockup();
        @(negedge clk);
        reset_n4 = 1'b0;
        en4      = 1'b0;
        clr4     = 1'b0;
        @(negedge clk);
        reset_n4 = 1'b1;
        step4(1'b1);
        step4(1'b1);
        checks++;
        if (count4 !== 4'b1000) begin failures++; $display("FAIL lock_pre got=%b exp=1000", count4); end
        force dut4.g_bit[0].u_bit.count_q = 1'b1;
        force dut4.g_bit[1].u_bit.count_q = 1'b1;
        force dut4.g_bit[2].u_bit.count_q = 1'b1;
        force dut4.g_bit[3].u_bit.count_q = 1'b1;
        #1;
        checks++;
        if (count4 !== 4'b1111) begin failures++; $display("FAIL lock_force got=%b exp=1111", count4); end
        step4(1'b1);
        checks++;
        if (tap4 !== 4'b0000 || phi1_4 !== 1'b1) begin
            failures++; $display("FAIL lock_tap got tap=%b phi1=%b exp 0000 1", tap4, phi1_4);
        end
        release dut4.g_bit[0].u_bit.count_q;
        release dut4.g_bit[1].u_bit.count_q;
        release dut4.g_bit[2].u_bit.count_q;
        release dut4.g_bit[3].u_bit.count_q;
        step4(1'b1);
        checks++;
        if (count4 !== 4'b0000 || wrap4 !== 1'b0 || phi2_4 !== 1'b1) begin
            failures++; $display("FAIL lock_commit got count=%b wrap=%b phi2=%b exp 0000 0 1", count4, wrap4, phi2_4);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        reset_n4 = 1'b0;
        en4      = 1'b0;
        clr4     = 1'b0;
        test_reset();
        test_sequence();
        test_en_gaps();
        test_clr();
        test_wrap_period();
        test_async_reset();
        test_lockup();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
